multicycle_ctrl_fsm: RTL and testbench

Parametrised successor to the multi-cycle RV32I control FSM. It decodes opcode/funct3 into per-state datapath enables for the shared-ALU multi-cycle core, and adds:
- conditional branches, JALR and AUIPC;
- a variable-latency memory handshake;
- illegal-opcode detection with optional halt;
- an instruction-retire counter.

It sits between the instruction register and the datapath mux and enable inputs.

---
 rtl/multicycle_ctrl_fsm.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Control FSM for a shared-ALU multi-cycle RV32I core. Decodes opcode/funct3
// from the instruction register into per-state datapath mux selects and write
// enables. Supports loads/stores with a variable-latency memory handshake,
// R/I ALU ops, LUI, AUIPC, JAL, JALR, conditional branches, illegal-opcode
// detection (halt or skip) and a wrapping retired-instruction counter.
//
// Parameters
//   MEM_WAIT_EN     : 1 = FETCH/MEM_RD/MEM_WR wait for mem_ready, 0 = ignore it
//   HALT_ON_ILLEGAL : 1 = illegal opcode parks in HALT, 0 = skip back to FETCH
//   CNT_W           : width of retire_cnt
//
// Ports
//   clk, rst_n                 : clock, synchronous active-low reset
//   opcode, funct3             : IR[6:0], IR[14:12]
//   alu_zero, alu_lt, alu_ltu  : ALU compare flags for branches
//   mem_ready                  : memory completes the current request
//   mem_req, sel_mem_addr      : memory request, address select (0 PC, 1 alu_reg)
//   we_ir, we_mdr              : instruction / memory-data register loads
//   sel_alu_src_a/b, alu_op    : ALU operand selects and operation class
//   sel_result                 : result bus select (alu_reg/mdr/pc_plus_4/imm)
//   we_pc, we_pc_plus_4, we_old_pc, we_alu_reg, we_rf, we_mem : write enables
//   retire, retire_cnt         : completion pulse and running count
//   illegal, halted            : illegal-instruction flag, FSM parked in HALT
// All outputs read 0 while rst_n is low.
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter logic MEM_WAIT_EN     = 1'b1,
  parameter logic HALT_ON_ILLEGAL = 1'b1,
  parameter int   CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             sel_mem_addr,
  output logic             we_ir,
  output logic             we_mdr,
  output logic [1:0]       sel_alu_src_a,
  output logic [1:0]       sel_alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       sel_result,
  output logic             we_pc,
  output logic             we_pc_plus_4,
  output logic             we_old_pc,
  output logic             we_alu_reg,
  output logic             we_rf,
  output logic             we_mem,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             illegal,
  output logic             halted
);

  // One-hot state encoding
  localparam logic [13:0] S_FETCH    = 14'h0001;
  localparam logic [13:0] S_DECODE   = 14'h0002;
  localparam logic [13:0] S_EXE_ADDR = 14'h0004;
  localparam logic [13:0] S_MEM_RD   = 14'h0008;
  localparam logic [13:0] S_WB_MEM   = 14'h0010;
  localparam logic [13:0] S_MEM_WR   = 14'h0020;
  localparam logic [13:0] S_EXE_R    = 14'h0040;
  localparam logic [13:0] S_EXE_I    = 14'h0080;
  localparam logic [13:0] S_WB_ALU   = 14'h0100;
  localparam logic [13:0] S_JAL_PC   = 14'h0200;
  localparam logic [13:0] S_EXE_JALR = 14'h0400;
  localparam logic [13:0] S_JALR_PC  = 14'h0800;
  localparam logic [13:0] S_BRANCH   = 14'h1000;
  localparam logic [13:0] S_HALT     = 14'h2000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [13:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             illegal_q, illegal_d;
  // Write-back result select chosen at DECODE so WB_ALU stays a pure
  // function of registered state (11 LUI, 10 JAL/JALR, 00 otherwise).
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic             mem_rdy;
  logic             taken;
  logic             dec_illegal;

  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal assigned in this block gets a default here first, so
    // no path through the case leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    wb_sel_d      = wb_sel_q;
    illegal_d     = HALT_ON_ILLEGAL ? illegal_q : 1'b0;
    dec_illegal   = 1'b0;
    mem_req       = 1'b0;
    sel_mem_addr  = 1'b0;
    we_ir         = 1'b0;
    we_mdr        = 1'b0;
    sel_alu_src_a = 2'b00;
    sel_alu_src_b = 2'b00;
    alu_op        = 2'b00;
    sel_result    = 2'b00;
    we_pc         = 1'b0;
    we_pc_plus_4  = 1'b0;
    we_old_pc     = 1'b0;
    we_alu_reg    = 1'b0;
    we_rf         = 1'b0;
    we_mem        = 1'b0;
    retire        = 1'b0;
    halted        = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req       = 1'b1;
        sel_alu_src_b = 2'b10;
        if (mem_rdy) begin
          we_ir        = 1'b1;
          we_pc        = 1'b1;
          sel_result   = 2'b10;
          we_pc_plus_4 = 1'b1;
          we_old_pc    = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        // alu_reg = old_pc + imm: branch/JAL target and AUIPC result
        sel_alu_src_a = 2'b10;
        sel_alu_src_b = 2'b01;
        we_alu_reg    = 1'b1;
        wb_sel_d      = 2'b00;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_EXE_ADDR;
          OP_R:              state_d = S_EXE_R;
          OP_I:              state_d = S_EXE_I;
          OP_AUIPC:          state_d = S_WB_ALU;
          OP_LUI: begin
            state_d  = S_WB_ALU;
            wb_sel_d = 2'b11;
          end
          OP_JAL: begin
            state_d  = S_JAL_PC;
            wb_sel_d = 2'b10;
          end
          OP_JALR: begin
            state_d  = S_EXE_JALR;
            wb_sel_d = 2'b10;
          end
          OP_BRANCH: begin
            if (funct3[2:1] == 2'b01) dec_illegal = 1'b1;
            else                      state_d     = S_BRANCH;
          end
          default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        end
      end
      S_EXE_ADDR: begin
        sel_alu_src_a = 2'b01;
        sel_alu_src_b = 2'b01;
        we_alu_reg    = 1'b1;
        state_d       = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req      = 1'b1;
        sel_mem_addr = 1'b1;
        if (mem_rdy) begin
          we_mdr  = 1'b1;
          state_d = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        sel_result = 2'b01;
        we_rf      = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        // we_mem stays high for the whole request; completion is mem_ready
        mem_req      = 1'b1;
        sel_mem_addr = 1'b1;
        we_mem       = 1'b1;
        if (mem_rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXE_R: begin
        sel_alu_src_a = 2'b01;
        sel_alu_src_b = 2'b00;
        alu_op        = 2'b01;
        we_alu_reg    = 1'b1;
        state_d       = S_WB_ALU;
      end
      S_EXE_I: begin
        sel_alu_src_a = 2'b01;
        sel_alu_src_b = 2'b01;
        alu_op        = 2'b10;
        we_alu_reg    = 1'b1;
        state_d       = S_WB_ALU;
      end
      S_WB_ALU: begin
        sel_result = wb_sel_q;
        we_rf      = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL_PC, S_JALR_PC: begin
        sel_result = 2'b00;
        we_pc      = 1'b1;
        state_d    = S_WB_ALU;
      end
      S_EXE_JALR: begin
        sel_alu_src_a = 2'b01;
        sel_alu_src_b = 2'b01;
        we_alu_reg    = 1'b1;
        state_d       = S_JALR_PC;
      end
      S_BRANCH: begin
        sel_alu_src_a = 2'b01;
        sel_alu_src_b = 2'b00;
        alu_op        = 2'b11;
        sel_result    = 2'b00;
        we_pc         = taken;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_FETCH;   // non-one-hot code recovers to FETCH
    endcase

    // Reset is synchronous, so outputs are squashed combinationally while it
    // is held: an aborted instruction writes nothing.
    if (!rst_n) begin
      mem_req       = 1'b0;
      sel_mem_addr  = 1'b0;
      we_ir         = 1'b0;
      we_mdr        = 1'b0;
      sel_alu_src_a = 2'b00;
      sel_alu_src_b = 2'b00;
      alu_op        = 2'b00;
      sel_result    = 2'b00;
      we_pc         = 1'b0;
      we_pc_plus_4  = 1'b0;
      we_old_pc     = 1'b0;
      we_alu_reg    = 1'b0;
      we_rf         = 1'b0;
      we_mem        = 1'b0;
      retire        = 1'b0;
      halted        = 1'b0;
    end
  end

  assign retire_cnt = rst_n ? cnt_q : '0;
  assign illegal    = rst_n & illegal_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      wb_sel_q  <= 2'b00;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      wb_sel_q  <= wb_sel_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//
// Scoreboard bench for multicycle_ctrl_fsm. Two instances: dut_a with default
// parameters (memory wait, halt on illegal, 16-bit counter) and dut_b with
// MEM_WAIT_EN=0, HALT_ON_ILLEGAL=0, CNT_W=2. The stimulus process drives one
// cycle at a time and pushes the hand-derived control word expected for that
// cycle; the monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero, alu_lt, alu_ltu, mem_ready;

  logic        a_mem_req, a_sel_mem_addr, a_we_ir, a_we_mdr;
  logic [1:0]  a_src_a, a_src_b, a_alu_op, a_sel_result;
  logic        a_we_pc, a_we_pc_plus_4, a_we_old_pc, a_we_alu_reg, a_we_rf, a_we_mem;
  logic        a_retire, a_illegal, a_halted;
  logic [15:0] a_cnt;

  logic        b_mem_req, b_sel_mem_addr, b_we_ir, b_we_mdr;
  logic [1:0]  b_src_a, b_src_b, b_alu_op, b_sel_result;
  logic        b_we_pc, b_we_pc_plus_4, b_we_old_pc, b_we_alu_reg, b_we_rf, b_we_mem;
  logic        b_retire, b_illegal, b_halted;
  logic [1:0]  b_cnt;

  multicycle_ctrl_fsm dut_a (
    .clk(clk), .rst_n(rst_a), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .sel_mem_addr(a_sel_mem_addr), .we_ir(a_we_ir), .we_mdr(a_we_mdr),
    .sel_alu_src_a(a_src_a), .sel_alu_src_b(a_src_b), .alu_op(a_alu_op),
    .sel_result(a_sel_result), .we_pc(a_we_pc), .we_pc_plus_4(a_we_pc_plus_4),
    .we_old_pc(a_we_old_pc), .we_alu_reg(a_we_alu_reg), .we_rf(a_we_rf), .we_mem(a_we_mem),
    .retire(a_retire), .retire_cnt(a_cnt), .illegal(a_illegal), .halted(a_halted)
  );

  multicycle_ctrl_fsm #(.MEM_WAIT_EN(1'b0), .HALT_ON_ILLEGAL(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_b), .opcode(opcode), .funct3(funct3),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .sel_mem_addr(b_sel_mem_addr), .we_ir(b_we_ir), .we_mdr(b_we_mdr),
    .sel_alu_src_a(b_src_a), .sel_alu_src_b(b_src_b), .alu_op(b_alu_op),
    .sel_result(b_sel_result), .we_pc(b_we_pc), .we_pc_plus_4(b_we_pc_plus_4),
    .we_old_pc(b_we_old_pc), .we_alu_reg(b_we_alu_reg), .we_rf(b_we_rf), .we_mem(b_we_mem),
    .retire(b_retire), .retire_cnt(b_cnt), .illegal(b_illegal), .halted(b_halted)
  );

  typedef struct packed {
    logic       mem_req, sel_mem_addr, we_ir, we_mdr;
    logic [1:0] src_a, src_b, alu_op, sel_result;
    logic       we_pc, we_pc_plus_4, we_old_pc, we_alu_reg, we_rf, we_mem;
    logic       retire, illegal, halted;
  } ctl_t;

  typedef struct {
    logic        which;
    string       name;
    ctl_t        ctl;
    logic [15:0] cnt;
  } exp_t;

  typedef enum {
    K_FETCH, K_DECODE, K_EXE_ADDR, K_MEM_RD, K_WB_MEM, K_MEM_WR, K_EXE_R,
    K_EXE_I, K_WB_ALU, K_JAL_PC, K_EXE_JALR, K_JALR_PC, K_BRANCH, K_HALT, K_RST
  } kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  ctl_t act_a, act_b;
  assign act_a = {a_mem_req, a_sel_mem_addr, a_we_ir, a_we_mdr, a_src_a, a_src_b, a_alu_op,
                  a_sel_result, a_we_pc, a_we_pc_plus_4, a_we_old_pc, a_we_alu_reg, a_we_rf,
                  a_we_mem, a_retire, a_illegal, a_halted};
  assign act_b = {b_mem_req, b_sel_mem_addr, b_we_ir, b_we_mdr, b_src_a, b_src_b, b_alu_op,
                  b_sel_result, b_we_pc, b_we_pc_plus_4, b_we_old_pc, b_we_alu_reg, b_we_rf,
                  b_we_mem, b_retire, b_illegal, b_halted};

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] cnt_m [2];
  logic [1:0]  ill_m;

  // Control word expected in each state, straight from the state table.
  // f: ready (FETCH/MEM_RD/MEM_WR), taken (BRANCH), sel_result (WB_ALU).
  function automatic ctl_t spec_ctl(kind_e k, logic [1:0] f);
    ctl_t c;
    c = '0;
    case (k)
      K_FETCH: begin
        c.mem_req = 1'b1; c.src_b = 2'b10;
        if (f[0]) begin
          c.we_ir = 1'b1; c.we_pc = 1'b1; c.sel_result = 2'b10;
          c.we_pc_plus_4 = 1'b1; c.we_old_pc = 1'b1;
        end
      end
      K_DECODE:   begin c.src_a = 2'b10; c.src_b = 2'b01; c.we_alu_reg = 1'b1; end
      K_EXE_ADDR: begin c.src_a = 2'b01; c.src_b = 2'b01; c.we_alu_reg = 1'b1; end
      K_MEM_RD:   begin c.mem_req = 1'b1; c.sel_mem_addr = 1'b1; c.we_mdr = f[0]; end
      K_WB_MEM:   begin c.sel_result = 2'b01; c.we_rf = 1'b1; c.retire = 1'b1; end
      K_MEM_WR: begin
        c.mem_req = 1'b1; c.sel_mem_addr = 1'b1; c.we_mem = 1'b1; c.retire = f[0];
      end
      K_EXE_R: begin c.src_a = 2'b01; c.alu_op = 2'b01; c.we_alu_reg = 1'b1; end
      K_EXE_I: begin
        c.src_a = 2'b01; c.src_b = 2'b01; c.alu_op = 2'b10; c.we_alu_reg = 1'b1;
      end
      K_WB_ALU:   begin c.we_rf = 1'b1; c.retire = 1'b1; c.sel_result = f; end
      K_JAL_PC:   begin c.we_pc = 1'b1; end
      K_JALR_PC:  begin c.we_pc = 1'b1; end
      K_EXE_JALR: begin c.src_a = 2'b01; c.src_b = 2'b01; c.we_alu_reg = 1'b1; end
      K_BRANCH:   begin c.src_a = 2'b01; c.alu_op = 2'b11; c.we_pc = f[0]; c.retire = 1'b1; end
      K_HALT:     begin c.halted = 1'b1; end
      default:    ;
    endcase
    return c;
  endfunction

  // One clock cycle: push the expectation, then advance past the edge.
  task automatic step(input logic w, input kind_e k, input logic [1:0] f, input string nm);
    exp_t e;
    e.which = w;
    e.name  = nm;
    e.ctl   = spec_ctl(k, f);
    if (k == K_RST) begin
      if (w) rst_b = 1'b0; else rst_a = 1'b0;
      e.cnt = 16'd0;
    end else begin
      e.ctl.illegal = ill_m[w];
      e.cnt         = cnt_m[w];
    end
    sb.push_back(e);
    @(posedge clk); #1;
    if (k == K_RST) begin
      if (w) rst_b = 1'b1; else rst_a = 1'b1;
      cnt_m[w] = 16'd0;
      ill_m[w] = 1'b0;
    end else if (e.ctl.retire) begin
      cnt_m[w] = (cnt_m[w] + 16'd1) & (w ? 16'h0003 : 16'hFFFF);
    end
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
  endtask

  task automatic r_type(input logic w);
    set_op(OP_R, 3'b000);
    step(w, K_FETCH,  2'd1, "r_fetch");
    step(w, K_DECODE, 2'd0, "r_decode");
    step(w, K_EXE_R,  2'd0, "r_exe");
    step(w, K_WB_ALU, 2'd0, "r_wb");
  endtask

  task automatic branch(input logic [2:0] f3, input logic z, input logic lt,
                        input logic ltu, input logic tk);
    set_op(OP_BRANCH, f3);
    alu_zero = z; alu_lt = lt; alu_ltu = ltu;
    step(1'b0, K_FETCH,  2'd1, "br_fetch");
    step(1'b0, K_DECODE, 2'd0, "br_decode");
    step(1'b0, K_BRANCH, {1'b0, tk}, "br_taken");
  endtask

  // Monitor: compares whatever the DUT presents against the queued word.
  exp_t        e_m;
  ctl_t        act_m;
  logic [15:0] cnt_act;
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e_m     = sb.pop_front();
      act_m   = e_m.which ? act_b : act_a;
      cnt_act = e_m.which ? {14'd0, b_cnt} : a_cnt;
      n_cmp++;
      if (act_m !== e_m.ctl || cnt_act !== e_m.cnt) begin
        n_bad++;
        $display("FAIL %s (dut_%s): got ctl=%06h cnt=%0d, want ctl=%06h cnt=%0d",
                 e_m.name, e_m.which ? "b" : "a", act_m, cnt_act, e_m.ctl, e_m.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    set_op(OP_R, 3'b000);
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = 1'b1;
    cnt_m[0] = 16'd0; cnt_m[1] = 16'd0; ill_m = 2'b00;
    @(posedge clk); #1;

    // ---------------- dut_a: defaults (rst_b held low) ----------------
    step(1'b0, K_RST, 2'd0, "reset_a0");
    step(1'b0, K_RST, 2'd0, "reset_a1");

    // add x0,x1,x2 (0x00208033)
    r_type(1'b0);

    // lw with three stall cycles in MEM_RD: 8 cycles total
    set_op(OP_LOAD, 3'b010);
    step(1'b0, K_FETCH,    2'd1, "lw_fetch");
    step(1'b0, K_DECODE,   2'd0, "lw_decode");
    step(1'b0, K_EXE_ADDR, 2'd0, "lw_exe_addr");
    mem_ready = 1'b0;
    step(1'b0, K_MEM_RD,   2'd0, "lw_stall1");
    step(1'b0, K_MEM_RD,   2'd0, "lw_stall2");
    step(1'b0, K_MEM_RD,   2'd0, "lw_stall3");
    mem_ready = 1'b1;
    step(1'b0, K_MEM_RD,   2'd1, "lw_ready");
    step(1'b0, K_WB_MEM,   2'd0, "lw_wb");

    // sw with one FETCH stall and one MEM_WR stall
    set_op(OP_STORE, 3'b010);
    mem_ready = 1'b0;
    step(1'b0, K_FETCH,    2'd0, "sw_fetch_stall");
    mem_ready = 1'b1;
    step(1'b0, K_FETCH,    2'd1, "sw_fetch");
    step(1'b0, K_DECODE,   2'd0, "sw_decode");
    step(1'b0, K_EXE_ADDR, 2'd0, "sw_exe_addr");
    mem_ready = 1'b0;
    step(1'b0, K_MEM_WR,   2'd0, "sw_stall");
    mem_ready = 1'b1;
    step(1'b0, K_MEM_WR,   2'd1, "sw_done");

    // Branch taken table: f3, zero, lt, ltu, taken
    branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    branch(3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    branch(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
    branch(3'b001, 1'b1, 1'b1, 1'b1, 1'b0);
    branch(3'b100, 1'b1, 1'b1, 1'b0, 1'b1);
    branch(3'b100, 1'b0, 1'b0, 1'b1, 1'b0);
    branch(3'b101, 1'b1, 1'b0, 1'b1, 1'b1);
    branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
    branch(3'b110, 1'b1, 1'b0, 1'b1, 1'b1);
    branch(3'b110, 1'b0, 1'b1, 1'b0, 1'b0);
    branch(3'b111, 1'b0, 1'b1, 1'b0, 1'b1);
    branch(3'b111, 1'b1, 1'b0, 1'b1, 1'b0);

    // LUI, AUIPC, I-type, JAL, JALR
    set_op(OP_LUI, 3'b000);
    step(1'b0, K_FETCH,    2'd1, "lui_fetch");
    step(1'b0, K_DECODE,   2'd0, "lui_decode");
    step(1'b0, K_WB_ALU,   2'd3, "lui_wb");
    set_op(OP_AUIPC, 3'b000);
    step(1'b0, K_FETCH,    2'd1, "auipc_fetch");
    step(1'b0, K_DECODE,   2'd0, "auipc_decode");
    step(1'b0, K_WB_ALU,   2'd0, "auipc_wb");
    set_op(OP_I, 3'b000);
    step(1'b0, K_FETCH,    2'd1, "addi_fetch");
    step(1'b0, K_DECODE,   2'd0, "addi_decode");
    step(1'b0, K_EXE_I,    2'd0, "addi_exe");
    step(1'b0, K_WB_ALU,   2'd0, "addi_wb");
    set_op(OP_JAL, 3'b000);
    step(1'b0, K_FETCH,    2'd1, "jal_fetch");
    step(1'b0, K_DECODE,   2'd0, "jal_decode");
    step(1'b0, K_JAL_PC,   2'd0, "jal_pc");
    step(1'b0, K_WB_ALU,   2'd2, "jal_wb");
    set_op(OP_JALR, 3'b000);
    step(1'b0, K_FETCH,    2'd1, "jalr_fetch");
    step(1'b0, K_DECODE,   2'd0, "jalr_decode");
    step(1'b0, K_EXE_JALR, 2'd0, "jalr_exe");
    step(1'b0, K_JALR_PC,  2'd0, "jalr_pc");
    step(1'b0, K_WB_ALU,   2'd2, "jalr_wb");

    // Branch funct3=010 is illegal: halt, sticky flag, no retire
    set_op(OP_BRANCH, 3'b010);
    step(1'b0, K_FETCH,    2'd1, "bill_fetch");
    step(1'b0, K_DECODE,   2'd0, "bill_decode");
    ill_m[0] = 1'b1;
    set_op(OP_R, 3'b000);
    step(1'b0, K_HALT,     2'd0, "bill_halt1");
    step(1'b0, K_HALT,     2'd0, "bill_halt2");
    step(1'b0, K_RST,      2'd0, "bill_reset");
    step(1'b0, K_FETCH,    2'd1, "bill_after_reset");
    step(1'b0, K_DECODE,   2'd0, "post_decode");
    step(1'b0, K_EXE_R,    2'd0, "post_exe");
    step(1'b0, K_WB_ALU,   2'd0, "post_wb");

    // opcode 0x7F halts; one reset cycle recovers with zero count
    set_op(7'h7F, 3'b000);
    step(1'b0, K_FETCH,    2'd1, "ill7f_fetch");
    step(1'b0, K_DECODE,   2'd0, "ill7f_decode");
    ill_m[0] = 1'b1;
    step(1'b0, K_HALT,     2'd0, "ill7f_halt1");
    step(1'b0, K_HALT,     2'd0, "ill7f_halt2");
    step(1'b0, K_RST,      2'd0, "ill7f_reset");
    step(1'b0, K_FETCH,    2'd1, "ill7f_after_reset");
    rst_a = 1'b0;

    // ---------------- dut_b: no wait, skip illegal, CNT_W=2 ----------------
    mem_ready = 1'b0;   // ignored by dut_b
    step(1'b1, K_RST, 2'd0, "reset_b");
    for (int i = 0; i < 5; i++) r_type(1'b1);   // count 1,2,3,0,1

    set_op(OP_LOAD, 3'b010);
    step(1'b1, K_FETCH,    2'd1, "b_lw_fetch");
    step(1'b1, K_DECODE,   2'd0, "b_lw_decode");
    step(1'b1, K_EXE_ADDR, 2'd0, "b_lw_exe_addr");
    step(1'b1, K_MEM_RD,   2'd1, "b_lw_mem");
    step(1'b1, K_WB_MEM,   2'd0, "b_lw_wb");
    set_op(OP_STORE, 3'b010);
    step(1'b1, K_FETCH,    2'd1, "b_sw_fetch");
    step(1'b1, K_DECODE,   2'd0, "b_sw_decode");
    step(1'b1, K_EXE_ADDR, 2'd0, "b_sw_exe_addr");
    step(1'b1, K_MEM_WR,   2'd1, "b_sw_mem");

    // Illegal skipped: flag pulses during the following FETCH only
    set_op(7'h7F, 3'b000);
    step(1'b1, K_FETCH,    2'd1, "b_ill_fetch");
    step(1'b1, K_DECODE,   2'd0, "b_ill_decode");
    ill_m[1] = 1'b1;
    set_op(OP_R, 3'b000);
    step(1'b1, K_FETCH,    2'd1, "b_ill_pulse");
    ill_m[1] = 1'b0;
    step(1'b1, K_DECODE,   2'd0, "b_ill_cleared");
    step(1'b1, K_EXE_R,    2'd0, "b_r_exe");
    step(1'b1, K_WB_ALU,   2'd0, "b_r_wb");

    // Reset during EXE_R aborts the instruction
    step(1'b1, K_FETCH,    2'd1, "b_abort_fetch");
    step(1'b1, K_DECODE,   2'd0, "b_abort_decode");
    step(1'b1, K_RST,      2'd0, "b_abort_reset");
    step(1'b1, K_FETCH,    2'd1, "b_abort_fetch_again");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
